// File: rtl/alu.sv
// Registered single-cycle ALU. Every cycle it computes one operation and its
// {N,Z,C,V} status, and both appear on the outputs after the next rising clock edge.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MOV = 4'b1000;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] shr_s;
  logic [SHW-1:0]   shamt_s;
  logic             shift_oob_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic [3:0]       flags_s;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       flags_r;

  // Operation units, all evaluated in parallel every cycle.
  always_comb begin
    sum_s       = {1'b0, op1} + {1'b0, op2};
    diff_s      = op1 - op2;
    prod_s      = op1 * op2;
    shamt_s     = op2[SHW-1:0];
    // Any shift amount of WIDTH or more (including upper bits set) clears the result.
    shift_oob_s = (op2 >= SHIFT_LIMIT);
    if (op2 == {WIDTH{1'b0}}) begin
      quot_s = {WIDTH{1'b1}};
    end else begin
      quot_s = op1 / op2;
    end
    if (shift_oob_s) begin
      shl_s = {WIDTH{1'b0}};
      shr_s = {WIDTH{1'b0}};
    end else begin
      shl_s = op1 << shamt_s;
      shr_s = op1 >> shamt_s;
    end
  end

  // Result select plus carry/overflow, which only add and subtract produce.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_s[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = diff_s;
        carry_s = (op1 >= op2);
        ovf_s   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_s[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_MUL: res_s = prod_s;
      OP_DIV: res_s = quot_s;
      OP_AND: res_s = op1 & op2;
      OP_OR:  res_s = op1 | op2;
      OP_SHL: res_s = shl_s;
      OP_SHR: res_s = shr_s;
      OP_MOV: res_s = op1;
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
    flags_s = {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), carry_s, ovf_s};
  end

  // Output register; reset clears it asynchronously, so an in-flight result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {WIDTH{1'b0}};
      flags_r  <= 4'b0000;
    end else begin
      result_r <= res_s;
      flags_r  <= flags_s;
    end
  end

  assign result = result_r;
  assign flags  = flags_r;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors plus randomized operations checked
// against an arithmetic reference model; a separate monitor pops and compares.
module tb_alu;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ALUControl;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] result;
  logic [3:0]  flags;

  exp_t q[$];
  int   n_checks;
  int   n_fails;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUControl(ALUControl),
    .op1(op1), .op2(op2), .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic over the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, s;
    longint sa, sb, ss;
    logic [31:0] r;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = ua + ub; r = s[31:0]; c = s[32]; ss = sa + sb;
              v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
      4'd1: begin r = a - b; c = (ua >= ub); ss = sa - sb;
              v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
      4'd2: begin s = ua * ub; r = s[31:0]; end
      4'd3: r = (ub == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = (ub >= 32) ? 32'd0 : 32'(ua << ub);
      4'd7: r = (ub >= 32) ? 32'd0 : 32'(ua >> ub);
      4'd8: r = a;
      default: r = 32'd0;
    endcase
    e.res = r;
    e.flg = {r[31], (r == 32'd0), c, v};
    e.name = "";
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    exp_t e;
    @(negedge clk);
    ALUControl = op; op1 = a; op2 = b;
    e = model(op, a, b);
    e.name = name;
    q.push_back(e);
  endtask

  task automatic issue_dir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [3:0] f, input bit has_f,
                           input string name);
    exp_t e;
    @(negedge clk);
    ALUControl = op; op1 = a; op2 = b;
    e = model(op, a, b);
    e.res = r;
    if (has_f) e.flg = f;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: each edge presents the response to the operation sampled on it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.name, " result"}, result, e.res);
      check({e.name, " flags"}, {28'd0, flags}, {28'd0, e.flg});
    end
  end

  initial begin
    logic [31:0] edges [6];
    logic [31:0] a, b;
    logic [3:0]  op;
    exp_t        e;
    edges = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd31};
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; ALUControl = 4'd0; op1 = 32'd0; op2 = 32'd0;
    #1;
    check("reset result", result, 32'd0);
    check("reset flags", {28'd0, flags}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue_dir(4'b0000, 32'd7, 32'd2, 32'd9, 4'b0000, 1, "add7_2");
    issue_dir(4'b0001, 32'd7, 32'd2, 32'd5, 4'b0010, 1, "sub7_2");
    issue_dir(4'b0010, 32'd10, 32'd2, 32'd20, 4'b0000, 0, "mul");
    issue_dir(4'b0011, 32'd3, 32'd2, 32'd1, 4'b0000, 0, "div");
    issue_dir(4'b0100, 32'h1F, 32'h15, 32'h15, 4'b0000, 0, "and");
    issue_dir(4'b0101, 32'h1F, 32'h15, 32'h1F, 4'b0000, 0, "or");
    issue_dir(4'b0110, 32'h1F, 32'd5, 32'h3E0, 4'b0000, 0, "shl");
    issue_dir(4'b0111, 32'h1F, 32'd5, 32'd0, 4'b0100, 1, "shr");
    issue_dir(4'b1000, 32'd2, 32'd5, 32'd2, 4'b0000, 0, "mov");
    issue_dir(4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1, "add_ovf");
    issue_dir(4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000, 1, "sub_borrow");
    issue_dir(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1, "add_carry");
    issue_dir(4'b0011, 32'd55, 32'd0, 32'hFFFF_FFFF, 4'b1000, 1, "div0");
    issue_dir(4'b0110, 32'h1F, 32'd32, 32'd0, 4'b0100, 1, "shl32");
    issue_dir(4'b0111, 32'h8000_0000, 32'h1_0000, 32'd0, 4'b0100, 1, "shr_big");
    issue_dir(4'b0110, 32'hABCD, 32'd0, 32'hABCD, 4'b0000, 1, "shl0");
    issue_dir(4'b1111, 32'd9, 32'd9, 32'd0, 4'b0100, 1, "op1111");

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin a = edges[$urandom_range(0, 5)]; b = edges[$urandom_range(0, 5)]; end
        1: begin a = $urandom; b = 32'($urandom_range(0, 40)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(op, a, b, "rand");

      if (i == 150) begin
        // Reset pulse between edges drops the pending op; first edge after release recaptures it.
        @(negedge clk);
        ALUControl = 4'b0000; op1 = 32'd100; op2 = 32'd23;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("pulse result", result, 32'd0);
        check("pulse flags", {28'd0, flags}, 32'd0);
        #1;
        rst_n = 1'b1;
        e = model(4'b0000, 32'd100, 32'd23);
        e.name = "post_reset";
        q.push_back(e);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be supported for any value from 8 to 64.
REQ-002 clk  input  1  sole clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ALUControl  input  4  operation select.
REQ-005 op1  input  WIDTH  first operand, unsigned unless stated otherwise.
REQ-006 op2  input  WIDTH  second operand or shift amount.
REQ-007 result  output  WIDTH  registered operation result.
REQ-008 flags  output  4  registered status {N,Z,C,V}: flags[3]=N, flags[2]=Z, flags[1]=C, flags[0]=V.

Function
REQ-009 Inputs are sampled on each rising clk edge; result and flags SHALL reflect that cycle's inputs after exactly one cycle of latency, with no handshake and a new operation accepted every cycle.
REQ-010 ALUControl SHALL select the operation as follows:
- 0000: result = op1 + op2, mod 2^WIDTH.
- 0001: result = op1 - op2, mod 2^WIDTH.
- 0010: result = low WIDTH bits of the unsigned product op1*op2.
- 0011: result = unsigned quotient op1/op2, truncated.
- 0100: result = op1 AND op2.
- 0101: result = op1 OR op2.
- 0110: result = op1 logical shift left by op2.
- 0111: result = op1 logical shift right by op2, zero fill.
- 1000: result = op1 (move).
REQ-011 Divide by zero (0011 with op2=0) SHALL give result = all ones, with N and Z computed from that value and C=V=0.
REQ-012 Shifts: if op2 >= WIDTH (any upper bits set), result SHALL be 0; shift amount 0 SHALL return op1 unchanged.
REQ-013 Codes 1001-1111 SHALL give result = 0 and flags = 0100.
REQ-014 N SHALL equal result[WIDTH-1] and Z SHALL be 1 iff result == 0, for every operation.
REQ-015 For add, C SHALL be the carry out of bit WIDTH-1.
REQ-016 For subtract, C SHALL be 1 iff op1 >= op2 unsigned (no borrow).
REQ-017 For add and subtract, V SHALL be 1 iff the two's-complement signed result overflows.
REQ-018 For all other operations, C and V SHALL be 0.
REQ-019 The datapath SHALL be single-cycle combinational logic ahead of the output register, with no multicycle or iterative units.

Reset
REQ-020 While rst_n = 0, result SHALL be 0 and flags SHALL be 0000, asserted immediately and independently of clk.
REQ-021 Assertion of rst_n mid-stream SHALL discard any pending result.
REQ-022 After rst_n deasserts, the first rising clk edge SHALL capture the current inputs, and the outputs SHALL be valid after that edge.

Verification
REQ-023 Basic arithmetic, WIDTH=32, one operation per cycle, checking the output one cycle later:
- op1=7, op2=2, 0000 -> result=9, flags=0000.
- op1=7, op2=2, 0001 -> result=5, flags=0010.
- op1=10, op2=2, 0010 -> result=20.
- op1=3, op2=2, 0011 -> result=1.
REQ-024 Logic, shift and move operations:
- op1=0x1F, op2=0x15, 0100 -> result=0x15.
- op1=0x1F, op2=0x15, 0101 -> result=0x1F.
- op1=0x1F, op2=5, 0110 -> result=0x3E0.
- op1=0x1F, op2=5, 0111 -> result=0, flags=0100.
- op1=2, op2=5, 1000 -> result=2.
REQ-025 Overflow and borrow:
- op1=0x7FFFFFFF, op2=1, 0000 -> result=0x80000000, flags=1001.
- op1=0, op2=1, 0001 -> result=0xFFFFFFFF, flags=1000.
- op1=0xFFFFFFFF, op2=1, 0000 -> result=0, flags=0110.
REQ-026 Edge cases:
- op2=0 with 0011 -> result=0xFFFFFFFF, flags=1000.
- op2=32 with 0110 -> result=0.
- ALUControl=1111 -> result=0, flags=0100.
REQ-027 Back-to-back operations on consecutive cycles SHALL each appear exactly one cycle later, in order, with no bubbles.
REQ-028 Pulsing rst_n low between clock edges mid-stream SHALL immediately force result=0 and flags=0000; normal operation SHALL resume on the first edge after release.
